// File: rtl/snos_i2s_pkg.sv
// Shared types and defaults for the MCU I2S receive path.
//   i2s_rx_state_t : receiver frame-lock state (SYNC / LEFT / RIGHT)
//   i2s_sample_t   : one captured sample at the default width
//   SAMPLE_W_DEF, SLOT_MAX_DEF : default captured width and max slot length
package snos_i2s_pkg;
  localparam int SAMPLE_W_DEF = 24;
  localparam int SLOT_MAX_DEF = 64;

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} i2s_rx_state_t;

  typedef logic [SAMPLE_W_DEF-1:0] i2s_sample_t;
endpackage

// File: rtl/i2s_rx_sync.sv
// Input conditioning for the MCU I2S pins.
//   clk, reset_n      : system clock, synchronous active-low reset
//   bck, lrck, data   : asynchronous serial pins
//   bck_rise          : one-cycle pulse per synchronized bck rising edge
//   lrck_smp, data_smp: lrck/data aligned with bck_rise
// Every pin sees the same two-flop synchronizer; a third bck flop gives the
// edge detect, and lrck/data are registered alongside the edge pulse so all
// three outputs describe the same bck rising edge.
module i2s_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic bck,
  input  logic lrck,
  input  logic data,
  output logic bck_rise,
  output logic lrck_smp,
  output logic data_smp
);
  logic [2:0] bck_q;
  logic [1:0] lrck_q;
  logic [1:0] data_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bck_q    <= '0;
      lrck_q   <= '0;
      data_q   <= '0;
      bck_rise <= 1'b0;
      lrck_smp <= 1'b0;
      data_smp <= 1'b0;
    end else begin
      bck_q    <= {bck_q[1:0], bck};
      lrck_q   <= {lrck_q[0], lrck};
      data_q   <= {data_q[0], data};
      bck_rise <= bck_q[1] & ~bck_q[2];
      lrck_smp <= lrck_q[1];
      data_smp <= data_q[1];
    end
  end
endmodule

// File: rtl/i2s_mcu_rx.sv
// I2S receiver for the MCU audio path: deserializes standard I2S frames
// (MSB first, one-bit delay, lrck low = left) and hands left/right pairs to
// the snos datapath over valid/ready.
//   clk, reset_n            : 24 MHz clock, synchronous active-low reset
//   en                      : receive enable, low forces SYNC
//   i2s_mcu_bck/lrck/data   : asynchronous serial inputs
//   out_left, out_right     : held sample pair (MSB-aligned)
//   out_valid, out_ready    : output handshake
//   err_short/long/ovf      : one-cycle error pulses
//   locked                  : high while framed (LEFT/RIGHT)
// Optional: define I2S_MCU_RX_STATS_EN to add pair_cnt / err_cnt outputs.
module i2s_mcu_rx
  import snos_i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int SLOT_MAX = SLOT_MAX_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                i2s_mcu_bck,
  input  logic                i2s_mcu_lrck,
  input  logic                i2s_mcu_data,
  output logic [SAMPLE_W-1:0] out_left,
  output logic [SAMPLE_W-1:0] out_right,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                err_short,
  output logic                err_long,
  output logic                err_ovf,
  output logic                locked
`ifdef I2S_MCU_RX_STATS_EN
  ,
  output logic [15:0]         pair_cnt,
  output logic [15:0]         err_cnt
`endif
);
  localparam int CW = $clog2(SLOT_MAX + 1);
  localparam logic [CW-1:0] SLOT_LIM  = CW'(SLOT_MAX);
  localparam logic [CW-1:0] SHORT_LIM = CW'(SAMPLE_W);
  localparam logic [SAMPLE_W-1:0] MSB_ONE = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic rise, lrck_s, data_s;

  i2s_rx_sync u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .bck      (i2s_mcu_bck),
    .lrck     (i2s_mcu_lrck),
    .data     (i2s_mcu_data),
    .bck_rise (rise),
    .lrck_smp (lrck_s),
    .data_smp (data_s)
  );

  i2s_rx_state_t state, state_nx;
  logic [SAMPLE_W-1:0] word, wnext, left_hold;
  logic [CW-1:0] bitcnt, cnt_inc;
  logic lrck_prev, change;
  logic close, long_err, emit, load_left;
  logic short_nx, load_out, drop;

  assign change  = lrck_s ^ lrck_prev;
  assign cnt_inc = bitcnt + 1'b1;
  // Bits past SAMPLE_W shift the mask out to zero, so they are discarded.
  assign wnext   = word | (data_s ? (MSB_ONE >> bitcnt) : '0);
  assign locked  = (state != SYNC);

  assign short_nx = close && (cnt_inc < SHORT_LIM);
  assign load_out = emit && (!out_valid || out_ready);
  assign drop     = emit && out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= SYNC;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    close     = 1'b0;
    long_err  = 1'b0;
    emit      = 1'b0;
    load_left = 1'b0;
    if (!en) begin
      state_nx = SYNC;
    end else if (rise) begin
      case (state)
        SYNC: if (change && !lrck_s) state_nx = LEFT;
        LEFT: begin
          if (change) begin
            close     = 1'b1;
            load_left = 1'b1;
            state_nx  = RIGHT;
          end else if (cnt_inc == SLOT_LIM) begin
            long_err = 1'b1;
            state_nx = SYNC;
          end
        end
        RIGHT: begin
          if (change) begin
            close    = 1'b1;
            emit     = 1'b1;
            state_nx = LEFT;
          end else if (cnt_inc == SLOT_LIM) begin
            long_err = 1'b1;
            state_nx = SYNC;
          end
        end
        default: state_nx = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word      <= '0;
      bitcnt    <= '0;
      lrck_prev <= 1'b0;
      left_hold <= '0;
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      err_short <= short_nx;
      err_long  <= long_err;
      err_ovf   <= drop;
      // lrck history tracks the line even while disabled, so re-enabling
      // does not see a stale edge.
      if (rise) lrck_prev <= lrck_s;
      if (!en) begin
        word      <= '0;
        bitcnt    <= '0;
        left_hold <= '0;
      end else if (rise) begin
        if (state == SYNC || close || long_err) begin
          word   <= '0;
          bitcnt <= '0;
        end else begin
          word   <= wnext;
          bitcnt <= cnt_inc;
        end
        if (load_left) left_hold <= wnext;
      end
      // en=0 deliberately leaves a pending pair in place.
      if (load_out) begin
        out_left  <= left_hold;
        out_right <= wnext;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef I2S_MCU_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pair_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (load_out) pair_cnt <= pair_cnt + 16'd1;
      if (short_nx || long_err || drop) err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  // Statistics counters not built.
`endif
endmodule

// File: tb/tb_i2s_mcu_rx.sv
// Directed bench for i2s_mcu_rx: drives I2S frames at bck = clk/8 and checks
// pairs, error pulses, latency, overflow and reset behaviour.
module tb_i2s_mcu_rx;
  logic clk = 1'b0, reset_n = 1'b0, en = 1'b1, out_ready = 1'b1;
  logic bck = 1'b0, lrck = 1'b0, data = 1'b0;
  logic [23:0] out_left, out_right;
  logic out_valid, err_short, err_long, err_ovf, locked;
`ifdef I2S_MCU_RX_STATS_EN
  logic [15:0] pair_cnt, err_cnt;
`endif

  i2s_mcu_rx dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .i2s_mcu_bck  (bck),
    .i2s_mcu_lrck (lrck),
    .i2s_mcu_data (data),
    .out_left     (out_left),
    .out_right    (out_right),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .err_short    (err_short),
    .err_long     (err_long),
    .err_ovf      (err_ovf),
    .locked       (locked)
`ifdef I2S_MCU_RX_STATS_EN
    ,
    .pair_cnt     (pair_cnt),
    .err_cnt      (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, rise_cyc = 0, lat = 0;
  int pair_n = 0, short_n = 0, long_n = 0, ovf_n = 0;
  int p0, s0, l0, o0;
  logic ov_prev = 1'b0, prev_d = 1'b0;
  logic [23:0] last_l = '0, last_r = '0;

  always @(posedge clk) cyc++;
  always @(posedge bck) rise_cyc = cyc;

  // Observer: accepted pairs, error pulse counts, out_valid rise latency.
  always @(negedge clk) begin
    if (out_valid && !ov_prev) lat = cyc - rise_cyc;
    ov_prev = out_valid;
    if (out_valid && out_ready) begin
      pair_n++;
      last_l = out_left;
      last_r = out_right;
    end
    if (err_short) short_n++;
    if (err_long)  long_n++;
    if (err_ovf)   ovf_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bck period: lrck/data change on the falling edge, data one bit late.
  task automatic drive_bit(input logic l, input logic d);
    @(negedge clk);
    bck = 1'b0; lrck = l; data = prev_d; prev_d = d;
    repeat (4) @(negedge clk);
    bck = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_slot(input logic l, input logic [23:0] w, input int nb, input int len);
    for (int j = 0; j < len; j++) drive_bit(l, (j < nb) ? w[23-j] : 1'b0);
  endtask

  task automatic send_frame(input logic [23:0] lw, input logic [23:0] rw, input int nb, input int len);
    send_slot(1'b0, lw, nb, len);
    send_slot(1'b1, rw, nb, len);
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_left",  out_left, 0);
    chk("rst_right", out_right, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_errs", {err_short, err_long, err_ovf}, 0);

    // 64-bit frames, 24-bit data; first frame is discarded while syncing.
    p0 = pair_n; s0 = short_n;
    repeat (3) send_frame(24'hA5A5A5, 24'h5A5A5A, 24, 32);
    send_slot(1'b0, 24'h0, 0, 4);
    chk("t1_pairs", pair_n - p0, 2);
    chk("t1_left",  last_l, 24'hA5A5A5);
    chk("t1_right", last_r, 24'h5A5A5A);
    chk("t1_lat",   lat, 4);
    chk("t1_short", short_n - s0, 0);
    chk("t1_locked", locked, 1);

    // 16-bit slots: missing LSBs read zero, every closed slot is short.
    do_reset();
    p0 = pair_n; s0 = short_n;
    repeat (3) send_frame(24'h800100, 24'h123400, 16, 16);
    send_slot(1'b0, 24'h0, 0, 4);
    chk("t2_pairs", pair_n - p0, 2);
    chk("t2_left",  last_l, 24'h800100);
    chk("t2_right", last_r, 24'h123400);
    chk("t2_short", short_n - s0, 4);

    // lrck held low 70 bck after locking: long-slot error, back to SYNC.
    do_reset();
    p0 = pair_n; l0 = long_n;
    send_frame(24'h111111, 24'h222222, 24, 32);
    send_slot(1'b0, 24'hFFFFFF, 24, 70);
    chk("t3_long",   long_n - l0, 1);
    chk("t3_locked", locked, 0);
    chk("t3_pairs0", pair_n - p0, 0);
    send_frame(24'h0F0F0F, 24'hF0F0F0, 24, 32);
    send_frame(24'h123456, 24'h654321, 24, 32);
    send_slot(1'b0, 24'h0, 0, 4);
    chk("t3_pairs1", pair_n - p0, 1);
    chk("t3_left",  last_l, 24'h123456);
    chk("t3_right", last_r, 24'h654321);

    // Overflow: consumer stalled across two emits.
    do_reset();
    out_ready = 1'b0;
    o0 = ovf_n;
    send_frame(24'h999999, 24'h888888, 24, 32);
    send_frame(24'h111111, 24'h222222, 24, 32);
    send_frame(24'h333333, 24'h444444, 24, 32);
    send_frame(24'h555555, 24'h666666, 24, 32);
    chk("t4_hold_l", out_left, 24'h111111);
    chk("t4_hold_r", out_right, 24'h222222);
    chk("t4_valid",  out_valid, 1);
    chk("t4_ovf",    ovf_n - o0, 1);
    // Closing edge of the last frame; ready rises in the emit cycle.
    @(negedge clk);
    bck = 1'b0; lrck = 1'b0; data = prev_d; prev_d = 1'b0;
    repeat (4) @(negedge clk);
    bck = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_new_l",  out_left, 24'h555555);
    chk("t4_new_r",  out_right, 24'h666666);
    chk("t4_no_ovf", err_ovf, 0);
    repeat (2) @(negedge clk);
    chk("t4_ovf_total", ovf_n - o0, 1);
    chk("t4_drained", out_valid, 0);

    // Reset in the middle of a left slot.
    do_reset();
    send_frame(24'h999999, 24'h888888, 24, 32);
    send_frame(24'hA5A5A5, 24'h5A5A5A, 24, 32);
    send_slot(1'b0, 24'h777777, 24, 8);
    chk("t5_pre_l", out_left, 24'hA5A5A5);
    chk("t5_pre_locked", locked, 1);
    do_reset();
    chk("t5_rst_l", out_left, 0);
    chk("t5_rst_r", out_right, 0);
    chk("t5_rst_v", out_valid, 0);
    chk("t5_rst_locked", locked, 0);
    p0 = pair_n;
    send_frame(24'hABCDEF, 24'hFEDCBA, 24, 32);
    send_frame(24'h123456, 24'h654321, 24, 32);
    send_slot(1'b0, 24'h0, 0, 4);
    chk("t5_pairs", pair_n - p0, 1);
    chk("t5_left",  last_l, 24'h123456);
    chk("t5_right", last_r, 24'h654321);
`ifdef I2S_MCU_RX_STATS_EN
    chk("st_pairs", {16'h0, pair_cnt}, 1);
    chk("st_errs",  {16'h0, err_cnt}, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
